pll_reset_sequencer: RTL
========================

PLL_RESET_SEQUENCER -- requirements
Module: pll_reset_sequencer

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: synchroniser depth for `locked`; legal range ≥2.
REQ-002 SHALL have parameter LOCK_CYCLES, default 1024: consecutive cycles of synchronised lock required before release; legal range ≥1.
REQ-003 SHALL have parameter RST_STRETCH, default 16: cycles `rst_n_out` is held low after lock qualifies or after a soft reset; legal range ≥1.
REQ-004 SHALL have port clk  input  1  PLL output clock; the block's only clock.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset; board power-on reset.
REQ-006 SHALL have port locked  input  1  PLL lock flag, asynchronous to clk.
REQ-007 SHALL have port soft_rst_req  input  1  synchronous pulse requesting a system reset.
REQ-008 SHALL have port rst_n_out  output  1  system reset: asserts asynchronously, deasserts synchronously.
REQ-009 SHALL have port state  output  2  current FSM state, for debug.
REQ-010 SHALL have port loss_count  output  8  lock-loss event count; present only when the macro in Configuration is defined.

Function
REQ-011 SHALL pass `locked` through SYNC_STAGES flops to produce lock_sync before any use.
REQ-012 SHALL implement FSM states WAIT_LOCK=0, QUALIFY=1, STRETCH=2, RUN=3.
REQ-013 WAIT_LOCK SHALL go to QUALIFY, with the counter cleared to 0, on the first cycle lock_sync=1.
REQ-014 QUALIFY SHALL increment the counter each cycle lock_sync=1 and go to STRETCH, with the counter cleared, when counter==LOCK_CYCLES-1.
REQ-015 STRETCH SHALL count RST_STRETCH cycles, then go to RUN.
REQ-016 In QUALIFY or STRETCH, lock_sync=0 SHALL send the FSM to WAIT_LOCK and clear the counter.
REQ-017 RUN SHALL go to WAIT_LOCK on lock_sync=0, and to STRETCH (counter cleared) on soft_rst_req=1.
REQ-018 When lock loss and soft_rst_req occur in the same cycle, lock loss SHALL take priority.
REQ-019 soft_rst_req SHALL be ignored in every state other than RUN.
REQ-020 rst_n_out SHALL be a dedicated flop, loaded with (next_state==RUN), so it is high exactly while state==RUN and is glitch-free.
REQ-021 Latency: `locked` rises and stays high → rst_n_out rises SYNC_STAGES+1+LOCK_CYCLES+RST_STRETCH clk edges after the first sampling edge.
REQ-022 rst_n_out SHALL fall on the clk edge after lock_sync falls in RUN.
REQ-023 Counter width SHALL be $clog2(max(LOCK_CYCLES, RST_STRETCH)+1) bits; the counter SHALL never wrap.

Reset
REQ-024 rst_n low SHALL asynchronously set: synchroniser flops 0, state WAIT_LOCK, counter 0, rst_n_out 0, loss_count 0.
REQ-025 After rst_n rises, the full sequence (REQ-021) SHALL be required before rst_n_out deasserts; no shortcut applies, even if `locked` is already high.
REQ-026 rst_n asserted mid-sequence SHALL abort the sequence, with no residual counter state.

Configuration
REQ-027 With PLL_RST_LOSS_COUNT_EN defined, loss_count SHALL increment on every RUN→WAIT_LOCK transition and saturate at 255.
REQ-028 Without PLL_RST_LOSS_COUNT_EN, the loss_count port and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-029 State encodings SHALL live in the shared package pll_rst_pkg.
REQ-030 The synchroniser SHALL be the sub-module sync_1bit (parameter N_STAGES), reset to 0.
REQ-031 The FSM and counter SHALL be inline in pll_reset_sequencer.

Verification (SYNC_STAGES=2, LOCK_CYCLES=16, RST_STRETCH=4)
REQ-032 rst_n release, then locked=1 held → rst_n_out=1 exactly at edge 23; state passes 0→1→2→3.
REQ-033 locked=1 for 10 cycles, low for 1, then high → state returns to WAIT_LOCK; rst_n_out rises 23 edges after the re-rise.
REQ-034 In RUN, pulse soft_rst_req for 1 cycle → rst_n_out low for exactly 4 cycles, then high; loss_count unchanged.
REQ-035 In RUN, drop locked in the same cycle soft_rst_req=1 → state WAIT_LOCK; loss_count increments by 1 with the macro defined.
REQ-036 In STRETCH, assert rst_n asynchronously → rst_n_out=0 and state=0 immediately, without a clk edge.
REQ-037 With the macro defined, 300 lock-loss cycles from RUN → loss_count saturates at 255.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared definitions for the PLL reset sequencer: FSM state codes and helpers.
// Latency: n/a (definitions only).
// Backpressure: n/a (no handshake interfaces).
package pll_rst_pkg;

    // FSM state codes; also exported on the debug 'state' port
    localparam logic [1:0] ST_WAIT_LOCK = 2'd0;
    localparam logic [1:0] ST_QUALIFY   = 2'd1;
    localparam logic [1:0] ST_STRETCH   = 2'd2;
    localparam logic [1:0] ST_RUN       = 2'd3;

    // Saturating 8-bit increment for event counters that must never wrap
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sync_1bit.sv
// Single-bit multi-flop synchroniser for an asynchronous level input.
// Latency: N_STAGES clk edges from input change to output change.
// Backpressure: none; the output is a level that always follows the input.
module sync_1bit #(
    parameter int N_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [N_STAGES-1:0] sync_q;

    // Shift chain: bit 0 takes the raw input, the last bit is the safe output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[N_STAGES-2:0], d};
        end
    end

    assign q = sync_q[N_STAGES-1];

endmodule

// File: rtl/pll_reset_sequencer.sv
// System reset sequencer: waits for a qualified PLL lock, stretches reset, then releases it.
// Latency: rst_n_out rises SYNC_STAGES+1+LOCK_CYCLES+RST_STRETCH edges after lock is first sampled.
// Backpressure: none; soft_rst_req is honoured only in RUN. Optional loss counter: PLL_RST_LOSS_COUNT_EN.
module pll_reset_sequencer
    import pll_rst_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_CYCLES = 1024,
    parameter int RST_STRETCH = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       locked,
    input  logic       soft_rst_req,
    output logic       rst_n_out,
    output logic [1:0] state
`ifdef PLL_RST_LOSS_COUNT_EN
    ,
    output logic [7:0] loss_count
`endif
);

    // Counter is shared by QUALIFY and STRETCH, so size it for the longer of the two
    localparam int CNT_MAX = (LOCK_CYCLES > RST_STRETCH) ? LOCK_CYCLES : RST_STRETCH;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] LOCK_LAST    = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(RST_STRETCH - 1);
    localparam logic [CNT_W-1:0] CNT_ONE      = CNT_W'(1);

    logic             lock_sync;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // 'locked' comes from the PLL's own domain logic and must be synchronised before use
    sync_1bit #(
        .N_STAGES(SYNC_STAGES)
    ) u_lock_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (locked),
        .q    (lock_sync)
    );

    // Next-state and counter logic; lock loss is tested first so it beats a soft reset
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_WAIT_LOCK: begin
                if (lock_sync) begin
                    state_nxt = ST_QUALIFY;
                    cnt_nxt   = '0;
                end
            end
            ST_QUALIFY: begin
                if (!lock_sync) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_nxt = ST_STRETCH;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_STRETCH: begin
                if (!lock_sync) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STRETCH_LAST) begin
                    state_nxt = ST_RUN;
                    cnt_nxt   = '0;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end
            ST_RUN: begin
                if (!lock_sync) begin
                    state_nxt = ST_WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (soft_rst_req) begin
                    state_nxt = ST_STRETCH;
                    cnt_nxt   = '0;
                end
            end
            default: begin
                state_nxt = ST_WAIT_LOCK;
                cnt_nxt   = '0;
            end
        endcase
    end

    // State and counter registers; board reset clears everything so no sequence survives it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_WAIT_LOCK;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Dedicated output flop: glitch-free, high exactly while the FSM sits in RUN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_n_out <= 1'b0;
        end else begin
            rst_n_out <= (state_nxt == ST_RUN);
        end
    end

`ifdef PLL_RST_LOSS_COUNT_EN
    // Count lock losses seen while the system was running; saturates rather than wrapping
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loss_count <= 8'd0;
        end else if ((state == ST_RUN) && (state_nxt == ST_WAIT_LOCK)) begin
            loss_count <= sat_inc8(loss_count);
        end
    end
`endif

endmodule
